// File: rtl/clk_edge_monitor.sv
// Synchronises a divided clock into clk, emits rise/fall ticks and checks each
// half-period for lock/fault. Define CLK_EDGE_MONITOR_GLITCH_FILTER_EN to reject 1-cycle pulses.
module clk_edge_monitor #(
    parameter int EXP_HALF = 2,
    parameter int TOL      = 0,
    parameter int LOCK_CNT = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             slow_clk_in,
    input  logic             clear_fault,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic [CNT_W-1:0] half_period,
    output logic             meas_valid,
    output logic             locked,
    output logic             fault
);

    // state   | meaning
    // ACQUIRE | waiting for a first edge; counter contents not trusted
    // TRACK   | measuring, counting consecutive good half-periods
    // LOCKED  | LOCK_CNT good half-periods seen in a row
    // FAULT   | lock lost or input stalled; held until clear_fault
    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        TRACK   = 2'd1,
        LOCKED  = 2'd2,
        FAULT   = 2'd3
    } state_t;

    localparam int GW   = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
    localparam int HI_I = EXP_HALF + TOL;
    localparam int LO_I = (EXP_HALF > TOL) ? (EXP_HALF - TOL) : 0;
    localparam logic [CNT_W:0]   HI_W    = (CNT_W + 1)'(HI_I);
    localparam logic [CNT_W:0]   LO_W    = (CNT_W + 1)'(LO_I);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [GW-1:0]    GOOD_LAST = GW'(LOCK_CNT - 1);

    logic s1, s2, s3;
    logic det_new, det_old;
    logic rise, fall, edge_det;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   cnt_ext;
    logic in_tol, stall;
    state_t state, state_nxt;
    logic [GW-1:0] good_cnt, good_nxt;
    logic meas_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= slow_clk_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

`ifdef CLK_EDGE_MONITOR_GLITCH_FILTER_EN
    // Accept a new level only once it has been seen on two consecutive samples.
    logic f_lvl, f_nxt;

    always_comb begin
        f_nxt = f_lvl;
        if (s2 == s3) begin
            f_nxt = s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_lvl <= 1'b0;
        end else begin
            f_lvl <= f_nxt;
        end
    end

    always_comb begin
        det_new = f_nxt;
        det_old = f_lvl;
    end
`else
    always_comb begin
        det_new = s2;
        det_old = s3;
    end
`endif

    always_comb begin
        rise     = det_new & ~det_old;
        fall     = ~det_new & det_old;
        edge_det = rise | fall;
    end

    // Saturating so a long stall never wraps back into the good window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (edge_det) begin
            cnt <= CNT_W'(1);
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        cnt_ext = {1'b0, cnt};
        in_tol  = (cnt_ext >= LO_W) && (cnt_ext <= HI_W);
        stall   = ~edge_det && (cnt_ext > HI_W);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ACQUIRE;
            good_cnt <= '0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        meas_en   = 1'b0;
        case (state)
            ACQUIRE: begin
                if (edge_det) begin
                    state_nxt = TRACK;
                    good_nxt  = '0;
                end
            end
            TRACK: begin
                if (edge_det) begin
                    meas_en = 1'b1;
                    if (in_tol) begin
                        good_nxt = good_cnt + 1'b1;
                        if (good_cnt == GOOD_LAST) begin
                            state_nxt = LOCKED;
                        end
                    end else begin
                        good_nxt = '0;
                    end
                end else if (stall) begin
                    state_nxt = ACQUIRE;
                    good_nxt  = '0;
                end
            end
            LOCKED: begin
                if (edge_det) begin
                    meas_en = 1'b1;
                    if (!in_tol) begin
                        state_nxt = FAULT;
                    end
                end else if (stall) begin
                    state_nxt = FAULT;
                end
            end
            FAULT: begin
                // clear_fault wins over a coincident edge, which then goes unmeasured.
                if (clear_fault) begin
                    state_nxt = ACQUIRE;
                    good_nxt  = '0;
                end else if (edge_det) begin
                    meas_en = 1'b1;
                end
            end
            default: begin
                state_nxt = ACQUIRE;
                good_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_tick   <= 1'b0;
            fall_tick   <= 1'b0;
            meas_valid  <= 1'b0;
            half_period <= '0;
        end else begin
            rise_tick  <= rise;
            fall_tick  <= fall;
            meas_valid <= meas_en;
            if (meas_en) begin
                half_period <= cnt;
            end
        end
    end

    always_comb begin
        locked = (state == LOCKED);
        fault  = (state == FAULT);
    end

endmodule

// File: tb/tb_clk_edge_monitor.sv
// Randomised bench for clk_edge_monitor: an event-level model predicts ticks,
// measurements and lock/fault from the input's change times.
module tb_clk_edge_monitor;

    localparam int EXP_HALF = 2;
    localparam int TOL      = 0;
    localparam int LOCK_CNT = 4;
    localparam int CNT_W    = 16;
    localparam int HI = EXP_HALF + TOL;
    localparam int LO = (EXP_HALF > TOL) ? (EXP_HALF - TOL) : 0;
`ifdef CLK_EDGE_MONITOR_GLITCH_FILTER_EN
    localparam int TICK_LAT = 4;
`else
    localparam int TICK_LAT = 3;
`endif

    logic             clk;
    logic             rst_n;
    logic             slow_clk_in;
    logic             clear_fault;
    logic             rise_tick;
    logic             fall_tick;
    logic [CNT_W-1:0] half_period;
    logic             meas_valid;
    logic             locked;
    logic             fault;

    clk_edge_monitor #(
        .EXP_HALF(EXP_HALF), .TOL(TOL), .LOCK_CNT(LOCK_CNT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .slow_clk_in(slow_clk_in), .clear_fault(clear_fault),
        .rise_tick(rise_tick), .fall_tick(fall_tick), .half_period(half_period),
        .meas_valid(meas_valid), .locked(locked), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_rise  = 0;
    int n_fall  = 0;
    bit chk_en  = 0;

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: works on sample indices k (posedges since reset release).
    // An input change accepted at sample k shows as a tick after posedge k+2.
    typedef enum int {M_ACQ, M_TRK, M_LCK, M_FLT} mode_t;
    mode_t mode;
    int k, k_last, good, prev_lvl, filt_lvl, hp_exp;
    int lvl, ev, cur, e, d;
    bit clr;
    bit rise_exp, fall_exp, mv_exp;
    int ev_q[$];

    function automatic bit good_half(input int h);
        return (h >= LO) && (h <= HI);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode = M_ACQ; k = 0; k_last = 0; good = 0;
            prev_lvl = 0; filt_lvl = 0; hp_exp = 0;
            rise_exp = 0; fall_exp = 0; mv_exp = 0;
            ev_q.delete();
        end else begin
            k++;
            lvl = int'(slow_clk_in);
            clr = clear_fault;
`ifdef CLK_EDGE_MONITOR_GLITCH_FILTER_EN
            ev = (lvl == prev_lvl && lvl != filt_lvl) ? lvl : -1;
            if (ev >= 0) filt_lvl = lvl;
`else
            ev = (lvl != prev_lvl) ? lvl : -1;
`endif
            prev_lvl = lvl;
            ev_q.push_back(ev);
            e = k - 2;
            cur = (ev_q.size() > 2) ? ev_q.pop_front() : -1;
            rise_exp = 0; fall_exp = 0; mv_exp = 0;
            if (cur >= 0) begin
                d = e - k_last;
                k_last = e;
                rise_exp = (cur == 1);
                fall_exp = (cur == 0);
                if (mode == M_ACQ) begin
                    mode = M_TRK; good = 0;
                end else if (mode == M_FLT && clr) begin
                    mode = M_ACQ; good = 0;
                end else begin
                    mv_exp = 1; hp_exp = d;
                    if (mode == M_TRK) begin
                        if (good_half(d)) begin
                            good++;
                            if (good == LOCK_CNT) mode = M_LCK;
                        end else begin
                            good = 0;
                        end
                    end else if (mode == M_LCK && !good_half(d)) begin
                        mode = M_FLT;
                    end
                end
            end else if (mode == M_FLT && clr) begin
                mode = M_ACQ; good = 0;
            end else if (e - k_last > HI) begin
                if (mode == M_TRK) begin
                    mode = M_ACQ; good = 0;
                end else if (mode == M_LCK) begin
                    mode = M_FLT;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk_val("rise_tick", rise_tick, rise_exp);
            chk_val("fall_tick", fall_tick, fall_exp);
            chk_val("meas_valid", meas_valid, mv_exp);
            chk_val("half_period", half_period, hp_exp);
            chk_val("locked", locked, mode == M_LCK);
            chk_val("fault", fault, mode == M_FLT);
            if (rise_tick) n_rise++;
            if (fall_tick) n_fall++;
        end
    end

    // Called at a negedge; flips the input and holds it for n cycles.
    task automatic toggle(input int n);
        slow_clk_in = ~slow_clk_in;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic lvl_in);
        rst_n = 1'b0;
        slow_clk_in = lvl_in;
        clear_fault = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, f0, r;
        rst_n = 1'b0;
        slow_clk_in = 1'b0;
        clear_fault = 1'b0;
        repeat (3) @(negedge clk);
        chk_val("rst_locked", locked, 0);
        chk_val("rst_fault", fault, 0);
        chk_val("rst_rise", rise_tick, 0);
        chk_val("rst_half", half_period, 0);
        rst_n = 1'b1;
        chk_en = 1;

        repeat (12) toggle(2);
        chk_val("lock_toggle2", locked, 1);
        chk_val("half_is_2", half_period, 2);

        repeat (10) @(negedge clk);
        chk_val("stall_fault", fault, 1);
        chk_val("stall_unlock", locked, 0);

        // edge coincident with clear_fault: ticked but not measured
        slow_clk_in = ~slow_clk_in;
        repeat (TICK_LAT - 1) @(negedge clk);
        clear_fault = 1'b1;
        @(negedge clk);
        clear_fault = 1'b0;
        chk_val("clr_edge_tick", rise_tick | fall_tick, 1);
        chk_val("clr_edge_meas", meas_valid, 0);
        chk_val("clr_fault", fault, 0);

        repeat (10) toggle(2);
        chk_val("relock", locked, 1);

        do_reset(1'b0);
        repeat (2) @(negedge clk);
        toggle(2); toggle(2); toggle(3);
        repeat (5) toggle(2);
        repeat (2) toggle(2);
        chk_val("track_lock", locked, 1);

        rst_n = 1'b0;
        slow_clk_in = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (TICK_LAT) @(posedge clk);
        #1;
        chk_val("high_at_rst_rise", rise_tick, 1);
        chk_val("high_at_rst_meas", meas_valid, 0);
        @(negedge clk);

        repeat (12) toggle(2);
        chk_val("pre_async_lock", locked, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_val("async_locked", locked, 0);
        chk_val("async_fault", fault, 0);
        chk_val("async_rise", rise_tick, 0);
        chk_val("async_fall", fall_tick, 0);
        chk_val("async_half", half_period, 0);
        chk_val("async_meas", meas_valid, 0);
        slow_clk_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        repeat (6) @(negedge clk);
        r0 = n_rise;
        f0 = n_fall;
        toggle(1);
        toggle(10);
`ifdef CLK_EDGE_MONITOR_GLITCH_FILTER_EN
        chk_val("pulse_rise_cnt", n_rise - r0, 0);
        chk_val("pulse_fall_cnt", n_fall - f0, 0);
`else
        chk_val("pulse_rise_cnt", n_rise - r0, 1);
        chk_val("pulse_fall_cnt", n_fall - f0, 1);
`endif
        chk_val("pulse_locked", locked, 0);
        chk_val("pulse_fault", fault, 0);

        repeat (600) begin
            r = $urandom_range(0, 19);
            if (r < 12) begin
                toggle(2);
            end else if (r < 17) begin
                toggle($urandom_range(1, 6));
            end else if (r < 19) begin
                toggle($urandom_range(7, 14));
            end else begin
                clear_fault = 1'b1;
                @(negedge clk);
                clear_fault = 1'b0;
            end
        end
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
